fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Producer side of the EX-stage operand-forwarding interface for the 5-stage RV32I pipeline.
- Holds the EX/MEM and MEM/WB pipeline registers.
- Drives the MEM-stage bypass value (add_result_o) and the WB result (result_o), plus the 2-bit forward selects consumed by the EX operand muxes.
- Detects load-use and branch hazards and drives stall/flush controls to IF/ID/EX.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid_i  in  1  EX instruction valid; 0 = bubble, not captured
ex_rd_i  in  RA_W  EX destination register
ex_reg_write_i  in  1  EX writes register file
ex_result_src_i  in  2  00 ALU, 01 load, 10 PC+4
ex_alu_result_i  in  XLEN  EX ALU result
ex_pc_plus4_i  in  XLEN  EX PC+4
ex_rs1_i, ex_rs2_i  in  RA_W  EX source registers
id_rs1_i, id_rs2_i  in  RA_W  ID source registers
ex_pc_src_i  in  1  branch/jump taken in EX
mem_rdata_i  in  XLEN  data-memory read data, combinational in MEM
add_result_o  out  XLEN  MEM bypass value
result_o  out  XLEN  WB result to register file and EX bypass
wb_rd_o  out  RA_W  register-file write address
wb_reg_write_o  out  1  register-file write enable
forward_ae_o, forward_be_o  out  2  00 regfile, 10 MEM, 01 WB
stall_f_o, stall_d_o  out  1  hold PC / IF-ID register
flush_d_o, flush_e_o  out  1  clear IF-ID / ID-EX register
stall_cnt_o, flush_cnt_o  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All MEM and WB registers clear to 0, giving wb_reg_write_o=0, wb_rd_o=0, result_o=0, add_result_o=0.
  - Forward selects read 00; all stall/flush outputs read 0.
- Reset asserted mid-stream discards in-flight MEM/WB contents; no write occurs after reset.
- MEM register, on each rising edge:
  - Captures rd, reg_write & ex_valid_i, result_src, alu_result, pc_plus4.
  - Bubble (ex_valid_i=0) captures reg_write=0.
- WB register, on each rising edge:
  - Captures rd, reg_write, result_src, alu_result, pc_plus4, mem_rdata_i from MEM.
- add_result_o: MEM pc_plus4 when MEM result_src=10, else MEM alu_result.
- result_o: combinational mux of WB regs by result_src: 00 alu, 01 rdata, 10 pc_plus4. Encoding 11 yields alu.
- Forward select for operand A (same rule for B with rs2):
  - 10 if MEM reg_write & MEM rd!=0 & MEM rd==ex_rs1_i.
  - Else 01 if WB reg_write & WB rd!=0 & WB rd==ex_rs1_i.
  - Else 00.
  - MEM beats WB when both match.
  - x0 is never forwarded.
- Load-use hazard (lw_stall):
  - Condition: ex_valid_i & ex_reg_write_i & ex_result_src_i==01 & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
  - lw_stall drives stall_f_o=stall_d_o=1 and flush_e_o=1.
- Branch:
  - ex_pc_src_i drives flush_d_o=1 and flush_e_o=1.
  - flush_e_o = lw_stall | ex_pc_src_i.
  - When branch and load-use coincide, the stall is still asserted; the flush of D wins at the IF-ID register, which is owned elsewhere.
- Latency:
  - Forward selects, stalls and flushes are combinational in the same cycle.
  - Results reach MEM one cycle after EX, WB two cycles after EX.
- Load in MEM is never selected as a bypass source, because lw_stall guarantees a one-cycle gap.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments each cycle stall_d_o=1.
  - flush_cnt_o increments each cycle flush_e_o=1.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops exist.

Decomposition:
- Package riscv_pipe_pkg holds:
  - RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10.
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - XLEN and RA_W defaults.
- One sub-module, hazard_detect (purely combinational), contains lw_stall, stall and flush generation.
- Forward-select and pipeline-register logic stay in the top block.

Test Plan:
- Back-to-back ALU dependency:
  - add x5 (alu=0x10) in EX, then EX rs1=5 on the next cycle.
  - Expect forward_ae_o=10, add_result_o=0x10.
  - One cycle later with rs2=5: forward_be_o=01, result_o=0x10.
- Double match, MEM rd=7 alu=0x22 and WB rd=7 alu=0x11, EX rs1=7 -> forward_ae_o=10, add_result_o=0x22.
- x0 guard, MEM rd=0 reg_write=1, EX rs1=0 -> forward_ae_o=00.
- Load-use:
  - lw x9 in EX, ID rs2=9 -> stall_f_o=stall_d_o=flush_e_o=1 for exactly one cycle.
  - Two cycles later, mem_rdata_i=0xDEADBEEF gives result_o=0xDEADBEEF and forward_be_o=01.
- Branch taken, ex_pc_src_i=1 -> flush_d_o=flush_e_o=1, stall_f_o=0. JAL x1 with pc_plus4=0x104 -> add_result_o=0x104 next cycle.
- Async reset mid-stream, rst_n low between edges with WB reg_write=1 -> wb_reg_write_o=0 immediately. With FWD_PERF_CNT_EN defined, counters read 0 and after 3 load-use cycles stall_cnt_o=3.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared RV32I pipeline constants: result-source and forward-select encodings, default widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    // Writeback source selected by result_src; 2'b11 is unused and falls back to the ALU value
    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_e;

    // EX operand mux select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundles the EX/ID/MEM-side inputs and the bypass/writeback/hazard outputs of fwd_hazard_unit.
// Latency: none (wiring only).
// Backpressure: none; the slave side answers with stall/flush controls instead of ready signals.
interface fwd_hazard_unit_if #(
    parameter int XLEN = riscv_pipe_pkg::XLEN_DEF,
    parameter int RA_W = riscv_pipe_pkg::RA_W_DEF
);
    logic            ex_valid_i;
    logic [RA_W-1:0] ex_rd_i;
    logic            ex_reg_write_i;
    logic [1:0]      ex_result_src_i;
    logic [XLEN-1:0] ex_alu_result_i;
    logic [XLEN-1:0] ex_pc_plus4_i;
    logic [RA_W-1:0] ex_rs1_i;
    logic [RA_W-1:0] ex_rs2_i;
    logic [RA_W-1:0] id_rs1_i;
    logic [RA_W-1:0] id_rs2_i;
    logic            ex_pc_src_i;
    logic [XLEN-1:0] mem_rdata_i;

    logic [XLEN-1:0] add_result_o;
    logic [XLEN-1:0] result_o;
    logic [RA_W-1:0] wb_rd_o;
    logic            wb_reg_write_o;
    logic [1:0]      forward_ae_o;
    logic [1:0]      forward_be_o;
    logic            stall_f_o;
    logic            stall_d_o;
    logic            flush_d_o;
    logic            flush_e_o;
    logic [31:0]     stall_cnt_o;
    logic [31:0]     flush_cnt_o;

    modport master (
        output ex_valid_i, ex_rd_i, ex_reg_write_i, ex_result_src_i, ex_alu_result_i,
               ex_pc_plus4_i, ex_rs1_i, ex_rs2_i, id_rs1_i, id_rs2_i, ex_pc_src_i, mem_rdata_i,
        input  add_result_o, result_o, wb_rd_o, wb_reg_write_o, forward_ae_o, forward_be_o,
               stall_f_o, stall_d_o, flush_d_o, flush_e_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_rd_i, ex_reg_write_i, ex_result_src_i, ex_alu_result_i,
               ex_pc_plus4_i, ex_rs1_i, ex_rs2_i, id_rs1_i, id_rs2_i, ex_pc_src_i, mem_rdata_i,
        output add_result_o, result_o, wb_rd_o, wb_reg_write_o, forward_ae_o, forward_be_o,
               stall_f_o, stall_d_o, flush_d_o, flush_e_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit_hazard_detect.sv
// Load-use and taken-branch hazard detection producing IF/ID stalls and ID/EX flushes.
// Latency: purely combinational, same cycle as the EX/ID inputs.
// Backpressure: is itself the backpressure source; a load-use holds IF/ID for one cycle.
module hazard_detect
    import riscv_pipe_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic            ex_valid,
    input  logic            ex_reg_write,
    input  logic [1:0]      ex_result_src,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            ex_pc_src,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e
);

    logic lw_stall;

    // A load in EX whose destination is read in ID cannot be bypassed in time: hold ID, bubble EX.
    // Stall and branch flush may coincide; the IF-ID register owner gives the flush priority.
    always_comb begin
        lw_stall = ex_valid && ex_reg_write && (ex_result_src == RESULT_MEM) &&
                   (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        stall_f  = lw_stall;
        stall_d  = lw_stall;
        flush_d  = ex_pc_src;
        flush_e  = lw_stall || ex_pc_src;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX/MEM and MEM/WB pipeline registers, EX operand forward selects and hazard controls; FWD_PERF_CNT_EN adds stall/flush counters.
// Latency: MEM one cycle after EX, WB two cycles; forward selects, stalls and flushes combinational.
// Backpressure: none accepted; hazards are resolved by driving stall/flush to IF/ID/EX.
module fwd_hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc_plus4;
    } mem_reg_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] rdata;
    } wb_reg_t;

    mem_reg_t mem_q;
    wb_reg_t  wb_q;
    logic     stall_d;
    logic     flush_e;

    // Highest-priority match first: the MEM value is newer than WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic mem_we, input logic [RA_W-1:0] mem_rd,
                                           input logic wb_we,  input logic [RA_W-1:0] wb_rd);
        if (mem_we && (mem_rd != '0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    // Advance EX -> MEM -> WB every cycle; a bubble in EX must never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q.rd         <= bus.ex_rd_i;
            mem_q.reg_write  <= bus.ex_reg_write_i && bus.ex_valid_i;
            mem_q.result_src <= bus.ex_result_src_i;
            mem_q.alu_result <= bus.ex_alu_result_i;
            mem_q.pc_plus4   <= bus.ex_pc_plus4_i;
            wb_q.rd          <= mem_q.rd;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.result_src  <= mem_q.result_src;
            wb_q.alu_result  <= mem_q.alu_result;
            wb_q.pc_plus4    <= mem_q.pc_plus4;
            wb_q.rdata       <= bus.mem_rdata_i;
        end
    end

    // MEM bypass carries the link address for JAL/JALR; a load here is never selected, so no rdata path.
    assign bus.add_result_o = (mem_q.result_src == RESULT_PC4) ? mem_q.pc_plus4 : mem_q.alu_result;

    // Writeback result mux; the unused encoding falls back to the ALU value.
    always_comb begin
        bus.result_o = wb_q.alu_result;
        case (wb_q.result_src)
            RESULT_MEM: bus.result_o = wb_q.rdata;
            RESULT_PC4: bus.result_o = wb_q.pc_plus4;
            default:    bus.result_o = wb_q.alu_result;
        endcase
    end

    assign bus.wb_rd_o        = wb_q.rd;
    assign bus.wb_reg_write_o = wb_q.reg_write;

    // Operand forward selects for the EX muxes.
    always_comb begin
        bus.forward_ae_o = fwd_sel(bus.ex_rs1_i, mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd);
        bus.forward_be_o = fwd_sel(bus.ex_rs2_i, mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd);
    end

    hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
        .ex_valid      (bus.ex_valid_i),
        .ex_reg_write  (bus.ex_reg_write_i),
        .ex_result_src (bus.ex_result_src_i),
        .ex_rd         (bus.ex_rd_i),
        .id_rs1        (bus.id_rs1_i),
        .id_rs2        (bus.id_rs2_i),
        .ex_pc_src     (bus.ex_pc_src_i),
        .stall_f       (bus.stall_f_o),
        .stall_d       (stall_d),
        .flush_d       (bus.flush_d_o),
        .flush_e       (flush_e)
    );

    assign bus.stall_d_o = stall_d;
    assign bus.flush_e_o = flush_e;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running event counters; they wrap silently at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_e) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`else
    assign bus.stall_cnt_o = '0;
    assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus queues expected field values, a monitor pops and compares.
// Latency: inputs driven 1 time unit after posedge, outputs compared on the following negedge.
// Backpressure: none; every queued expectation is consumed at the next compare point.
module tb_fwd_hazard_unit;

    localparam int F_ADD = 0, F_RES = 1, F_WRD = 2, F_WWE = 3, F_FA = 4, F_FB = 5;
    localparam int F_SF = 6, F_SD = 7, F_FD = 8, F_FE = 9, F_SC = 10, F_FC = 11;

`ifdef FWD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    typedef struct {
        int          fid;
        logic [31:0] val;
        string       nm;
    } chk_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_tog = 1'b0;
    chk_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    fwd_hazard_unit_if #(.XLEN(32), .RA_W(5)) bus ();

    fwd_hazard_unit #(.XLEN(32), .RA_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int fid);
        case (fid)
            F_ADD:   return bus.add_result_o;
            F_RES:   return bus.result_o;
            F_WRD:   return {27'd0, bus.wb_rd_o};
            F_WWE:   return {31'd0, bus.wb_reg_write_o};
            F_FA:    return {30'd0, bus.forward_ae_o};
            F_FB:    return {30'd0, bus.forward_be_o};
            F_SF:    return {31'd0, bus.stall_f_o};
            F_SD:    return {31'd0, bus.stall_d_o};
            F_FD:    return {31'd0, bus.flush_d_o};
            F_FE:    return {31'd0, bus.flush_e_o};
            F_SC:    return bus.stall_cnt_o;
            default: return bus.flush_cnt_o;
        endcase
    endfunction

    // Monitor: compare everything queued at each negedge, or immediately on an explicit strobe.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk or chk_tog);
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = actual(c.fid);
                checks++;
                if (act !== c.val) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h required 0x%0h", c.nm, act, c.val);
                end
            end
        end
    end

    task automatic exp(input string nm, input int fid, input logic [31:0] v);
        chk_t c;
        c.fid = fid;
        c.val = v;
        c.nm  = nm;
        sb_q.push_back(c);
    endtask

    task automatic hz(input string nm, input logic sf, input logic sd, input logic fd, input logic fe);
        exp({nm, ".stall_f"}, F_SF, {31'd0, sf});
        exp({nm, ".stall_d"}, F_SD, {31'd0, sd});
        exp({nm, ".flush_d"}, F_FD, {31'd0, fd});
        exp({nm, ".flush_e"}, F_FE, {31'd0, fe});
    endtask

    task automatic idle();
        bus.ex_valid_i      = 1'b0;
        bus.ex_rd_i         = '0;
        bus.ex_reg_write_i  = 1'b0;
        bus.ex_result_src_i = 2'b00;
        bus.ex_alu_result_i = '0;
        bus.ex_pc_plus4_i   = '0;
        bus.ex_rs1_i        = '0;
        bus.ex_rs2_i        = '0;
        bus.id_rs1_i        = '0;
        bus.id_rs2_i        = '0;
        bus.ex_pc_src_i     = 1'b0;
        bus.mem_rdata_i     = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] pc4);
        bus.ex_valid_i      = 1'b1;
        bus.ex_rd_i         = rd;
        bus.ex_reg_write_i  = we;
        bus.ex_result_src_i = src;
        bus.ex_alu_result_i = alu;
        bus.ex_pc_plus4_i   = pc4;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        // reset state, compared at the first negedge
        exp("rst.add", F_ADD, 0); exp("rst.res", F_RES, 0); exp("rst.wrd", F_WRD, 0);
        exp("rst.wwe", F_WWE, 0); exp("rst.fa", F_FA, 0);   exp("rst.fb", F_FB, 0);
        hz("rst", 0, 0, 0, 0);
        exp("rst.scnt", F_SC, 0); exp("rst.fcnt", F_FC, 0);

        // back-to-back ALU dependency on x5
        cyc(); rst_n = 1'b1; issue(5, 1, 2'b00, 32'h10, 0);
        exp("A.fa", F_FA, 0); exp("A.add", F_ADD, 0); hz("A", 0, 0, 0, 0);
        cyc(); issue(6, 1, 2'b00, 32'h20, 0); bus.ex_rs1_i = 5;
        exp("B.fa", F_FA, 2); exp("B.fb", F_FB, 0); exp("B.add", F_ADD, 32'h10);
        cyc(); bus.ex_rs2_i = 5;
        exp("C.fb", F_FB, 1); exp("C.fa", F_FA, 0); exp("C.res", F_RES, 32'h10);
        exp("C.wrd", F_WRD, 5); exp("C.wwe", F_WWE, 1); exp("C.add", F_ADD, 32'h20);
        cyc(); issue(7, 1, 2'b00, 32'h11, 0);
        exp("D.res", F_RES, 32'h20); exp("D.wrd", F_WRD, 6); exp("D.add", F_ADD, 0);

        // MEM and WB both hold x7: MEM wins
        cyc(); issue(7, 1, 2'b00, 32'h22, 0);
        cyc(); bus.ex_rs1_i = 7; bus.ex_rs2_i = 7;
        exp("F.fa", F_FA, 2); exp("F.fb", F_FB, 2); exp("F.add", F_ADD, 32'h22);
        exp("F.res", F_RES, 32'h11); exp("F.wrd", F_WRD, 7);
        cyc(); bus.ex_rs1_i = 7;
        exp("G.fa", F_FA, 1); exp("G.res", F_RES, 32'h22);

        // x0 is never forwarded from MEM or WB
        cyc(); issue(0, 1, 2'b00, 32'h33, 0);
        cyc();
        exp("I.fa", F_FA, 0); exp("I.fb", F_FB, 0); exp("I.add", F_ADD, 32'h33);
        cyc();
        exp("J.fa", F_FA, 0); exp("J.wwe", F_WWE, 1); exp("J.wrd", F_WRD, 0); exp("J.res", F_RES, 32'h33);

        // load-use on x9 through ID rs2
        cyc(); issue(9, 1, 2'b01, 32'h1000, 0); bus.id_rs1_i = 3; bus.id_rs2_i = 9;
        hz("K", 1, 1, 0, 1);
        cyc(); bus.id_rs2_i = 9; bus.mem_rdata_i = 32'hDEADBEEF;
        hz("L", 0, 0, 0, 0); exp("L.add", F_ADD, 32'h1000);
        cyc(); issue(10, 1, 2'b00, 32'h5, 0); bus.ex_rs2_i = 9;
        exp("M.fb", F_FB, 1); exp("M.res", F_RES, 32'hDEADBEEF); exp("M.wrd", F_WRD, 9);
        hz("M", 0, 0, 0, 0);

        // taken JAL x1, link 0x104
        cyc(); issue(1, 1, 2'b10, 32'h200, 32'h104); bus.ex_pc_src_i = 1'b1;
        hz("N", 0, 0, 1, 1);
        cyc();
        exp("O.add", F_ADD, 32'h104); hz("O", 0, 0, 0, 0);
        cyc(); bus.ex_rs1_i = 1;
        exp("P.res", F_RES, 32'h104); exp("P.fa", F_FA, 1); exp("P.wrd", F_WRD, 1);

        // branch and load-use together
        cyc(); issue(4, 1, 2'b01, 32'h40, 0); bus.id_rs1_i = 4; bus.ex_pc_src_i = 1'b1;
        hz("Q", 1, 1, 1, 1);

        // result_src 11 falls back to the ALU value
        cyc(); issue(12, 1, 2'b11, 32'h55, 32'h99); bus.id_rs1_i = 12;
        hz("R", 0, 0, 0, 0);
        cyc();
        exp("S.add", F_ADD, 32'h55);
        cyc();
        exp("T.res", F_RES, 32'h55);

        // loads that must not stall: rd=x0, bubble, no register write
        cyc(); issue(0, 1, 2'b01, 0, 0); bus.id_rs1_i = 0;
        hz("U0", 0, 0, 0, 0);
        cyc(); bus.ex_rd_i = 9; bus.ex_reg_write_i = 1'b1; bus.ex_result_src_i = 2'b01; bus.id_rs2_i = 9;
        hz("U1", 0, 0, 0, 0);
        cyc(); issue(9, 0, 2'b01, 0, 0); bus.id_rs2_i = 9;
        hz("U2", 0, 0, 0, 0);

        // asynchronous reset between edges with a live WB write
        cyc(); issue(8, 1, 2'b00, 32'h77, 0);
        cyc();
        cyc();
        exp("X.wwe", F_WWE, 1); exp("X.wrd", F_WRD, 8); exp("X.res", F_RES, 32'h77);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp("arst.wwe", F_WWE, 0); exp("arst.wrd", F_WRD, 0);
        exp("arst.res", F_RES, 0); exp("arst.add", F_ADD, 0);
        chk_tog = ~chk_tog;
        cyc();
        exp("Y.scnt", F_SC, 0); exp("Y.fcnt", F_FC, 0);

        // three load-use cycles after reset release
        for (int i = 0; i < 3; i++) begin
            cyc(); rst_n = 1'b1; issue(9, 1, 2'b01, 0, 0); bus.id_rs1_i = 9;
            hz($sformatf("Z%0d", i), 1, 1, 0, 1);
            exp($sformatf("Z%0d.scnt", i), F_SC, PERF * i);
            exp($sformatf("Z%0d.fcnt", i), F_FC, PERF * i);
        end
        cyc();
        hz("Z3", 0, 0, 0, 0);
        exp("Z3.scnt", F_SC, PERF * 3); exp("Z3.fcnt", F_FC, PERF * 3);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
